fpu_mult_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one combinational bfloat16 multiplier (`Mult`) between `NUM_REQ` requesters in the FPU. Each requester presents operand pairs over a valid/ready handshake. Granted pairs are registered, multiplied, and returned on a single tagged response channel that honours back-pressure. Sustained throughput is one product per cycle.

---
 rtl/fpu_mult_arb.sv | 171 +++++++++++++++++
 tb/tb_fpu_mult_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mult_arb.sv
// rtl/fpu_mult_arb.sv - two-stage pipeline sharing one bfloat16 multiplier among NUM_REQ requesters.
// Define FPU_MULT_ARB_RR_EN for round-robin grant; otherwise the lowest valid index wins.

// Combinational bf16 multiply: round-to-nearest-even, subnormals flush to zero, NaN is canonical.
module Mult (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_inst,
  output logic [15:0] o_c
);
  logic        w_sign;
  logic [7:0]  w_ea, w_eb;
  logic [6:0]  w_ma, w_mb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [15:0] w_prod;
  logic [8:0]  w_kept;
  logic [8:0]  w_rnd;
  logic        w_guard, w_sticky;
  logic [9:0]  w_exp;
  logic [6:0]  w_mant;
  logic        w_unused;

  assign w_sign   = i_a[15] ^ i_b[15];
  assign w_ea     = i_a[14:7];
  assign w_eb     = i_b[14:7];
  assign w_ma     = i_a[6:0];
  assign w_mb     = i_b[6:0];
  assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != 7'h0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != 7'h0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == 7'h0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == 7'h0);
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_prod   = {1'b1, w_ma} * {1'b1, w_mb};

  always_comb begin
    if (w_prod[15]) begin
      w_kept   = {1'b0, w_prod[15:8]};
      w_guard  = w_prod[7];
      w_sticky = |w_prod[6:0];
    end else begin
      w_kept   = {1'b0, w_prod[14:7]};
      w_guard  = w_prod[6];
      w_sticky = |w_prod[5:0];
    end
  end

  assign w_rnd  = w_kept + {8'd0, w_guard & (w_sticky | w_kept[0])};
  // Rounding carry-out means the mantissa wrapped to 1.0 of the next binade.
  assign w_exp  = {2'b00, w_ea} + {2'b00, w_eb} + {9'd0, w_prod[15]} + {9'd0, w_rnd[8]} - 10'd127;
  assign w_mant = w_rnd[8] ? 7'h00 : w_rnd[6:0];
  assign w_unused = i_inst ^ w_rnd[7];

  always_comb begin
    o_c = {w_sign, w_exp[7:0], w_mant};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      o_c = 16'h7FC0;
    else if (w_a_inf || w_b_inf)
      o_c = {w_sign, 8'hFF, 7'h00};
    else if (w_a_zero || w_b_zero || w_exp[9] || (w_exp == 10'd0))
      o_c = {w_sign, 15'h0000};
    else if (w_exp >= 10'd255)
      o_c = {w_sign, 8'hFF, 7'h00};
  end
endmodule

module fpu_mult_arb #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [15:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
);
  logic            r_s1_valid, r_s2_valid;
  logic [15:0]     r_s1_a, r_s1_b, r_s2_data;
  logic [ID_W-1:0] r_s1_id, r_s2_id;
  logic            w_s1_en, w_s2_en, w_found;
  logic [ID_W-1:0] w_win_idx, w_scan;
  logic [15:0]     w_prod;
  logic [15:0]     w_a_arr [NUM_REQ];
  logic [15:0]     w_b_arr [NUM_REQ];
`ifdef FPU_MULT_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;
`endif

  assign w_s2_en = !r_s2_valid | resp_ready;
  assign w_s1_en = !r_s1_valid | w_s2_en;

  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_scan    = '0;
`ifdef FPU_MULT_ARB_RR_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_win_idx = w_scan;
      end
    end
`else
    // Scanning downward lets the lowest valid index overwrite the others.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_scan = ID_W'(i);
      if (req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_win_idx = w_scan;
      end
    end
`endif
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_a_arr[g]   = req_a[16*g +: 16];
    assign w_b_arr[g]   = req_b[16*g +: 16];
    assign req_ready[g] = w_found & w_s1_en & (w_win_idx == ID_W'(g));
  end

  Mult u_mult (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .i_inst (1'b0),
    .o_c    (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_id    <= '0;
`ifdef FPU_MULT_ARB_RR_EN
      r_ptr      <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data  <= w_prod;
        r_s2_id    <= r_s1_id;
      end
      if (w_s1_en) begin
        r_s1_valid <= w_found;
        if (w_found) begin
          r_s1_a  <= w_a_arr[w_win_idx];
          r_s1_b  <= w_b_arr[w_win_idx];
          r_s1_id <= w_win_idx;
`ifdef FPU_MULT_ARB_RR_EN
          r_ptr   <= w_win_idx;
`endif
        end
      end
    end
  end

  assign resp_valid = r_s2_valid;
  assign resp_data  = r_s2_data;
  assign resp_id    = r_s2_id;
  assign busy       = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_fpu_mult_arb.sv
// tb/tb_fpu_mult_arb.sv - directed self-checking bench for fpu_mult_arb.
module tb_fpu_mult_arb;
  localparam int NUM_REQ = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data;
  logic        resp_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_mult_arb #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  // Record each response that will be consumed at the coming rising edge.
  always @(negedge clk)
    if (!rst && resp_valid && resp_ready) got_q.push_back({resp_id, resp_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_valid[idx] = 1'b1;
    #1;
    while (!req_ready[idx] && t < 50) begin
      tick();
      t++;
    end
    chk("send_accept", {31'd0, req_ready[idx]}, 32'd1);
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (busy && t < 50) begin
      tick();
      t++;
    end
    chk("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), {15'd0, got_q[i]}, {15'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", {16'd0, resp_data}, 32'h0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    rst = 1'b0;
    tick();

    // Single operation: 1.5 * 2.0 = 3.0
    req_a[15:0] = 16'h3FC0;
    req_b[15:0] = 16'h4000;
    req_valid = 2'b01;
    #1;
    chk("single_ready", {30'd0, req_ready}, 32'b01);
    tick();
    req_valid = 2'b00;
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_not_yet", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("single_valid", {31'd0, resp_valid}, 32'd1);
    chk("single_data", {16'd0, resp_data}, 32'h4040);
    chk("single_id", {31'd0, resp_id}, 32'd0);
    tick();
    chk("single_gone", {31'd0, resp_valid}, 32'd0);
    got_q.delete();

    // Contention from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    req_a = {16'h3F80, 16'h4000};
    req_b = {16'h4040, 16'h4000};
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 4; c++) begin
`ifdef FPU_MULT_ARB_RR_EN
      chk($sformatf("ctn_ready%0d", c), {30'd0, req_ready}, (c % 2 == 0) ? 32'b01 : 32'b10);
      exp_q.push_back((c % 2 == 0) ? {1'b0, 16'h4080} : {1'b1, 16'h4040});
`else
      chk($sformatf("ctn_ready%0d", c), {30'd0, req_ready}, 32'b01);
      exp_q.push_back({1'b0, 16'h4080});
`endif
      tick();
    end
    req_valid = 2'b00;
    wait_drain();
    check_q("ctn");

    // Back-pressure: stall five cycles with S2 full and S1 filled
    req_a[15:0] = 16'h3F80;
    req_b[15:0] = 16'h3F80;
    req_valid = 2'b01;
    #1;
    chk("bp_acc0", {30'd0, req_ready}, 32'b01);
    tick();
    resp_ready = 1'b0;
    req_a[15:0] = 16'h4000;
    req_b[15:0] = 16'h4000;
    #1;
    chk("bp_acc1", {30'd0, req_ready}, 32'b01);
    tick();
    req_a[15:0] = 16'h4040;
    req_b[15:0] = 16'h4000;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_ready%0d", c), {30'd0, req_ready}, 32'd0);
      chk($sformatf("bp_valid%0d", c), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp_data%0d", c), {16'd0, resp_data}, 32'h3F80);
      chk($sformatf("bp_busy%0d", c), {31'd0, busy}, 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_acc2", {30'd0, req_ready}, 32'b01);
    tick();
    req_a[15:0] = 16'h4080;
    req_b[15:0] = 16'h4080;
    #1;
    chk("bp_acc3", {30'd0, req_ready}, 32'b01);
    tick();
    req_a[15:0] = 16'hBF80;
    req_b[15:0] = 16'h4000;
    #1;
    chk("bp_acc4", {30'd0, req_ready}, 32'b01);
    tick();
    req_valid = 2'b00;
    wait_drain();
    exp_q.push_back({1'b0, 16'h3F80});
    exp_q.push_back({1'b0, 16'h4080});
    exp_q.push_back({1'b0, 16'h40C0});
    exp_q.push_back({1'b0, 16'h4180});
    exp_q.push_back({1'b0, 16'hC000});
    check_q("bp");

    // Special values
    send(1, 16'h7F80, 16'h0000);
    send(0, 16'hFF80, 16'h4000);
    send(1, 16'h7FC1, 16'h3F80);
    wait_drain();
    exp_q.push_back({1'b1, 16'h7FC0});
    exp_q.push_back({1'b0, 16'hFF80});
    exp_q.push_back({1'b1, 16'h7FC0});
    check_q("spec");

    // Asynchronous reset with both stages occupied
    resp_ready = 1'b0;
    send(0, 16'h4000, 16'h4000);
    send(1, 16'h3F80, 16'h3F80);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_valid", {31'd0, resp_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    #2;
    rst = 1'b0;
    resp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("mid_first_grant", {30'd0, req_ready}, 32'b01);
    tick();
    req_valid = 2'b00;
    wait_drain();
    exp_q.push_back({1'b0, 16'h4080});
    check_q("mid");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
